// File: rtl/div_mod_unit.sv
// Iterative unsigned divider for the modulo opcode. One quotient bit per cycle,
// MSB first, using restoring shift-subtract. Busy (div_state) stalls the control
// unit; result_valid pulses once with remainder, quotient and the launch tag.
module div_mod_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_ena,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] rd_tag_in,
    output logic             div_state,
    output logic             result_valid,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient,
    output logic [TAG_W-1:0] rd_tag_out,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  part_q, part_d;   // partial remainder
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH:0]    trial;
    logic              ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so the low WIDTH bits of the
    // difference are exact whenever the subtraction is taken.
    always_comb begin
        trial    = {part_q, dvd_q[WIDTH-1]};
        ge       = (trial >= {1'b0, dvs_q});
        rem_next = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], ge};
    end

    // Next-state and registered-output logic; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        part_d    = part_q;
        tag_d     = tag_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        rem_d     = rem_q;
        quo_d     = quo_q;
        tag_out_d = tag_out_q;
        dbz_d     = dbz_q;

        if (flush) begin
            state_d = StIdle;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    if (div_ena) begin
                        dvd_d  = dividend;
                        dvs_d  = divisor;
                        tag_d  = rd_tag_in;
                        part_d = '0;
                        cnt_d  = CntW'(WIDTH - 1);
                        dbz_d  = 1'b0;
                        if (divisor != '0) begin
                            state_d = StRun;
                            busy_d  = 1'b1;
                        end else begin
                            // Divide by zero resolves immediately.
                            state_d   = StDone;
                            valid_d   = 1'b1;
                            rem_d     = dividend;
                            quo_d     = '1;
                            tag_out_d = rd_tag_in;
                            dbz_d     = 1'b1;
                        end
                    end
                end
                StRun: begin
                    part_d = rem_next;
                    dvd_d  = quo_next;
                    cnt_d  = cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_d   = StDone;
                        busy_d    = 1'b0;
                        valid_d   = 1'b1;
                        rem_d     = rem_next;
                        quo_d     = quo_next;
                        tag_out_d = tag_q;
                    end
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            part_q    <= '0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            tag_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            part_q    <= part_d;
            tag_q     <= tag_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            tag_out_q <= tag_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign div_state    = busy_q;
    assign result_valid = valid_q;
    assign remainder    = rem_q;
    assign quotient     = quo_q;
    assign rd_tag_out   = tag_out_q;
    assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_div_mod_unit.sv
// Scoreboard bench for div_mod_unit: stimulus pushes expected results, a
// negedge monitor pops and compares on every result_valid pulse.
module tb_div_mod_unit;

    localparam int W = 16;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         div_ena;
    logic         flush;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [T-1:0] rd_tag_in;
    logic         div_state;
    logic         result_valid;
    logic [W-1:0] remainder;
    logic [W-1:0] quotient;
    logic [T-1:0] rd_tag_out;
    logic         div_by_zero;

    div_mod_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_ena      (div_ena),
        .flush        (flush),
        .dividend     (dividend),
        .divisor      (divisor),
        .rd_tag_in    (rd_tag_in),
        .div_state    (div_state),
        .result_valid (result_valid),
        .remainder    (remainder),
        .quotient     (quotient),
        .rd_tag_out   (rd_tag_out),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rem;
        logic [W-1:0] quo;
        logic [T-1:0] tag;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("remainder",   32'(remainder),   32'(e.rem));
                check("quotient",    32'(quotient),    32'(e.quo));
                check("rd_tag_out",  32'(rd_tag_out),  32'(e.tag));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                check("latency",     32'(cyc),         32'(e.cyc));
                check("busy_in_done", 32'(div_state),  32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one launch cycle; optionally record the expected result.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] t,
                          input logic [W-1:0] er, input logic [W-1:0] eq, input logic ed,
                          input bit push);
        exp_t e;
        if (push) begin
            e.rem = er;
            e.quo = eq;
            e.tag = t;
            e.dbz = ed;
            e.cyc = cyc + 1 + ((b == '0) ? 0 : W);
            sb.push_back(e);
        end
        div_ena   = 1'b1;
        dividend  = a;
        divisor   = b;
        rd_tag_in = t;
        step(1);
        div_ena   = 1'b0;
    endtask

    // Count busy cycles until the result pulse, bounded.
    task automatic wait_result(input int exp_busy, input string name);
        int  busy;
        bit  seen;
        busy = 0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                seen = 1;
                break;
            end
            if (div_state === 1'b1) busy++;
        end
        check({name, "_result_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_div_state"},    32'(div_state),    32'd0);
        check({name, "_result_valid"}, 32'(result_valid), 32'd0);
        check({name, "_remainder"},    32'(remainder),    32'd0);
        check({name, "_quotient"},     32'(quotient),     32'd0);
        check({name, "_rd_tag_out"},   32'(rd_tag_out),   32'd0);
        check({name, "_div_by_zero"},  32'(div_by_zero),  32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, er, eq;
        logic         ed;

        rst_n     = 1'b0;
        div_ena   = 1'b0;
        flush     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rd_tag_in = '0;
        step(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(2);

        // Basic and extreme directed vectors
        launch(16'd100, 16'd7, 4'd3, 16'd2, 16'd14, 1'b0, 1);
        wait_result(16, "basic");
        step(1);
        launch(16'hFFFF, 16'd1, 4'd1, 16'd0, 16'hFFFF, 1'b0, 1);
        wait_result(16, "max_by_1");
        step(1);
        launch(16'd5, 16'd9, 4'd2, 16'd5, 16'd0, 1'b0, 1);
        wait_result(16, "small_by_big");
        step(1);
        launch(16'hFFFF, 16'hFFFF, 4'd4, 16'd0, 16'd1, 1'b0, 1);
        wait_result(16, "equal");
        step(1);

        // Divide by zero: immediate result, never busy
        launch(16'h1234, 16'd0, 4'd6, 16'h1234, 16'hFFFF, 1'b1, 1);
        wait_result(0, "div_zero");
        step(1);

        // div_ena during RUN is ignored
        launch(16'd100, 16'd7, 4'd3, 16'd2, 16'd14, 1'b0, 1);
        step(3);
        div_ena   = 1'b1;
        dividend  = 16'd200;
        divisor   = 16'd3;
        rd_tag_in = 4'd5;
        step(1);
        div_ena   = 1'b0;
        step(25);
        check("ignore_pending", 32'(sb.size()), 32'd0);

        // Back-to-back launch in the DONE cycle
        launch(16'd100, 16'd7, 4'd3, 16'd2, 16'd14, 1'b0, 1);
        step(16);
        check("b2b_done_valid", 32'(result_valid), 32'd1);
        launch(16'd50, 16'd8, 4'd9, 16'd2, 16'd6, 1'b0, 1);
        wait_result(16, "b2b_second");
        step(1);

        // Flush at busy cycle 5: no result
        launch(16'd30, 16'd4, 4'd7, 16'd0, 16'd0, 1'b0, 0);
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_busy", 32'(div_state), 32'd0);
        step(25);

        // Reset at busy cycle 9: all outputs back to reset values, no result
        launch(16'd30, 16'd4, 4'd7, 16'd0, 16'd0, 1'b0, 0);
        step(8);
        rst_n = 1'b0;
        step(1);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        step(25);

        // Flush with div_ena in IDLE: no launch
        flush     = 1'b1;
        div_ena   = 1'b1;
        dividend  = 16'd9;
        divisor   = 16'd2;
        rd_tag_in = 4'd8;
        step(1);
        flush   = 1'b0;
        div_ena = 1'b0;
        check("flush_ena_busy", 32'(div_state), 32'd0);
        step(25);
        check("abort_pending", 32'(sb.size()), 32'd0);

        // Random operands against a reference model
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       begin b = W'($urandom); a = W'($urandom_range(0, 255)); end
                default: b = W'($urandom);
            endcase
            if (b == '0) begin
                er = a;
                eq = '1;
                ed = 1'b1;
            end else begin
                er = a % b;
                eq = a / b;
                ed = 1'b0;
            end
            launch(a, b, T'($urandom), er, eq, ed, 1);
            wait_result((b == '0) ? 0 : W, "rand");
            step(1);
        end

        step(5);
        check("final_pending", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
